state_sequencer: RTL and testbench

Instruction-execution FSM that produces the 4-bit state code consumed by dp_controller, which turns it into write/loada/loadb/loadc/loads/vsel.
- Accepts a start request with the opcode/op fields of the current instruction.
- Latches those fields and steps through the datapath micro-sequence for that instruction.
- Returns to wait and signals completion.

---
 rtl/risc_pkg.sv | 43 ++++
 rtl/instr_class.sv | 31 +++
 rtl/state_sequencer.sv | 123 ++++++++++++
 tb/tb_state_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared encodings for the instruction-execution sequencer and its datapath controller:
// state codes, instruction field constants, instruction classes and write-back selects.
package risc_pkg;

  typedef enum logic [3:0] {
    S_WAIT      = 4'b0000,
    S_DECODE    = 4'b0001,
    S_WRITE_IMM = 4'b0010,
    S_LOAD_AB   = 4'b0011,
    S_LOAD_B    = 4'b0100,
    S_LOAD_C    = 4'b0101,
    S_WRITE_C   = 4'b0110,
    S_LOAD_S    = 4'b0111
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_MVN  = 2'b11;
  localparam logic [1:0] OP_MOVI = 2'b10;
  localparam logic [1:0] OP_MOVR = 2'b00;

  // Register-file write-back source selects used by dp_controller.
  localparam logic [1:0] SEL_C   = 2'b00;
  localparam logic [1:0] SEL_IMM = 2'b01;

  typedef enum logic [2:0] {
    CLS_MOVI,
    CLS_REG2REG,
    CLS_ALU2,
    CLS_CMP,
    CLS_ILLEGAL
  } instr_class_t;

  // Steps after which the instruction has fully retired.
  function automatic logic is_terminal(input logic [3:0] code);
    return (code == S_WRITE_IMM) || (code == S_WRITE_C) || (code == S_LOAD_S);
  endfunction

endpackage

// File: rtl/instr_class.sv
// Combinational decode of the latched {opcode,op} pair into the micro-sequence class
// that the sequencer dispatches on.
module instr_class
  import risc_pkg::*;
#(
  parameter int OPC_W = 3,
  parameter int OP_W  = 2
) (
  input  logic [OPC_W-1:0] opcode_i,
  input  logic [OP_W-1:0]  op_i,
  output instr_class_t     cls_o
);

  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    cls_o = CLS_ILLEGAL;
    if (opcode_i == OPC_MOV) begin
      if (op_i == OP_MOVI)      cls_o = CLS_MOVI;
      else if (op_i == OP_MOVR) cls_o = CLS_REG2REG;
    end else if (opcode_i == OPC_ALU) begin
      unique case (op_i)
        OP_ADD,
        OP_AND:  cls_o = CLS_ALU2;
        OP_CMP:  cls_o = CLS_CMP;
        OP_MVN:  cls_o = CLS_REG2REG;
        default: cls_o = CLS_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/state_sequencer.sv
// Instruction-execution FSM: accepts a start request, latches the instruction fields and
// walks the datapath micro-sequence, emitting the state code consumed by dp_controller.
module state_sequencer
  import risc_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int OPC_W   = 3,
  parameter int OP_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [OP_W-1:0]    op,
  output logic [STATE_W-1:0] state,
  output logic               w,
  output logic               done,
  output logic               illegal
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [OPC_W-1:0]   opcode_q, opcode_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               done_q, done_d;
  logic               illegal_q, illegal_d;
  instr_class_t       cls;

  // Dispatch only ever looks at the latched fields, never the live inputs.
  instr_class #(
    .OPC_W (OPC_W),
    .OP_W  (OP_W)
  ) u_instr_class (
    .opcode_i (opcode_q),
    .op_i     (op_q),
    .cls_o    (cls)
  );

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    op_d      = op_q;
    done_d    = is_terminal(state_q);
    illegal_d = 1'b0;

    case (state_q)
      S_WAIT: begin
        if (s) begin
          opcode_d = opcode;
          op_d     = op;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        case (cls)
          CLS_MOVI:    state_d = S_WRITE_IMM;
          CLS_REG2REG: state_d = S_LOAD_B;
          CLS_ALU2,
          CLS_CMP:     state_d = S_LOAD_AB;
          default: begin
            state_d   = S_WAIT;
            illegal_d = 1'b1;
          end
        endcase
      end

      S_LOAD_AB: begin
        if (cls == CLS_ALU2) begin
          state_d = S_LOAD_C;
        end else if (cls == CLS_CMP) begin
          state_d = S_LOAD_S;
        end else begin
          state_d   = S_WAIT;
          illegal_d = 1'b1;
        end
      end

      S_LOAD_B: begin
        if (cls == CLS_REG2REG) begin
          state_d = S_LOAD_C;
        end else begin
          state_d   = S_WAIT;
          illegal_d = 1'b1;
        end
      end

      S_LOAD_C: state_d = S_WRITE_C;

      S_WRITE_IMM,
      S_WRITE_C,
      S_LOAD_S: state_d = S_WAIT;

      // Codes 1000-1111 have no meaning; recover to idle and flag it.
      default: begin
        state_d   = S_WAIT;
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_WAIT;
      opcode_q  <= '0;
      op_q      <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      op_q      <= op_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign w       = (state_q == S_WAIT);
  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_state_sequencer.sv
// Self-checking bench for state_sequencer: directed scenarios plus random traffic, checked
// against a model that expands each accepted instruction into its expected code sequence.
module tb_state_sequencer;

  logic       clk;
  logic       rst_n;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic [3:0] state;
  logic       w;
  logic       done;
  logic       illegal;

  state_sequencer #(
    .STATE_W (4),
    .OPC_W   (3),
    .OP_W    (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (s),
    .opcode  (opcode),
    .op      (op),
    .state   (state),
    .w       (w),
    .done    (done),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic       done;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_cur;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, got, want);
    end
  endtask

  // Expected codes seen after each edge, starting with the accepting edge.
  task automatic push_seq(input logic [2:0] opc_v, input logic [1:0] op_v);
    int   codes[$];
    logic legal;
    exp_t e;
    legal = 1'b1;
    case ({opc_v, op_v})
      5'b110_10:            codes = '{1, 2, 0};
      5'b110_00, 5'b101_11: codes = '{1, 4, 5, 6, 0};
      5'b101_00, 5'b101_10: codes = '{1, 3, 5, 6, 0};
      5'b101_01:            codes = '{1, 3, 7, 0};
      default: begin
        codes = '{1, 0};
        legal = 1'b0;
      end
    endcase
    for (int i = 0; i < codes.size(); i++) begin
      e.code = codes[i][3:0];
      e.done = (i == codes.size() - 1) && legal;
      e.ill  = (i == codes.size() - 1) && !legal;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_advance(input logic s_v, input logic [2:0] opc_v, input logic [1:0] op_v);
    if (exp_q.size() == 0 && s_v) push_seq(opc_v, op_v);
    if (exp_q.size() > 0) begin
      exp_cur = exp_q.pop_front();
    end else begin
      exp_cur.code = 4'd0;
      exp_cur.done = 1'b0;
      exp_cur.ill  = 1'b0;
    end
  endtask

  task automatic step(input logic s_v, input logic [2:0] opc_v, input logic [1:0] op_v);
    s      = s_v;
    opcode = opc_v;
    op     = op_v;
    model_advance(s_v, opc_v, op_v);
    @(posedge clk);
    #1;
    check("state",   32'(state),   32'(exp_cur.code));
    check("w",       32'(w),       32'(exp_cur.code == 4'd0));
    check("done",    32'(done),    32'(exp_cur.done));
    check("illegal", 32'(illegal), 32'(exp_cur.ill));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'b000, 2'b00);
  endtask

  logic [4:0] legal_tbl[6] = '{5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01, 5'b101_10, 5'b101_11};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    s      = 1'b0;
    opcode = 3'b000;
    op     = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",   32'(state),   32'd0);
    check("rst_w",       32'(w),       32'd1);
    check("rst_done",    32'(done),    32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Reset in the middle of an ADD, while in S_LOAD_C.
    step(1'b1, 3'b101, 2'b00);
    step(1'b0, 3'b101, 2'b00);
    step(1'b0, 3'b101, 2'b00);
    check("pre_rst_load_c", 32'(state), 32'h5);
    rst_n = 1'b0;
    #2;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_w",     32'(w),     32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // MOV imm.
    step(1'b1, 3'b110, 2'b10);
    idle(3);

    // ADD with opcode changed right after acceptance.
    step(1'b1, 3'b101, 2'b00);
    step(1'b0, 3'b110, 2'b00);
    step(1'b0, 3'b110, 2'b10);
    step(1'b0, 3'b111, 2'b11);
    step(1'b0, 3'b110, 2'b10);
    idle(2);

    // CMP then MVN with s held high; MVN accepted in the done cycle.
    repeat (4) step(1'b1, 3'b101, 2'b01);
    step(1'b1, 3'b101, 2'b11);
    repeat (4) step(1'b0, 3'b101, 2'b11);
    idle(2);

    // Illegal instruction.
    step(1'b1, 3'b111, 2'b00);
    idle(3);

    // s toggled while a MOV reg is running.
    step(1'b1, 3'b110, 2'b00);
    step(1'b1, 3'b110, 2'b10);
    step(1'b0, 3'b101, 2'b01);
    step(1'b1, 3'b111, 2'b11);
    step(1'b0, 3'b110, 2'b10);
    idle(2);

    // Random traffic, mostly legal instructions.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] f;
      if ($urandom_range(0, 3) != 0) f = legal_tbl[$urandom_range(0, 5)];
      else                           f = 5'($urandom);
      step(1'($urandom_range(0, 1)), f[4:2], f[1:0]);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
